// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS memory stage: load/store opcodes,
// access-size encoding, memory-stage FSM states and small decode helpers.
package mips_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  // Access size as carried in the EX/MM register; 2'b11 behaves as a word.
  typedef enum logic [1:0] {
    SZ_BYTE     = 2'b00,
    SZ_HALF     = 2'b01,
    SZ_WORD     = 2'b10,
    SZ_WORD_ALT = 2'b11
  } access_sz_e;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } mm_state_e;

  function automatic logic is_load_op(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_store_op(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // lbu/lhu zero-extend; every other load sign-extends (lw needs neither).
  function automatic logic is_unsigned_load(input logic [5:0] op);
    return (op == OP_LBU) || (op == OP_LHU);
  endfunction

  // Halves need addr[0]=0, words need addr[1:0]=0; bytes never misalign.
  function automatic logic is_misaligned(input access_sz_e sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      default: return |off;
    endcase
  endfunction

endpackage

// File: rtl/dm_lane_fmt.sv
// Combinational lane formatter for the data-memory bus.
// Store side: byte enables and lane replication of store data.
// Load side: lane extraction by byte offset with sign or zero extension.
module dm_lane_fmt
  import mips_pkg::*;
(
  input  access_sz_e  st_sz,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  access_sz_e  ld_sz,
  input  logic [1:0]  ld_off,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store side: enables follow the byte offset, data is copied to every lane.
  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    st_be    = 4'b1111;
    st_wdata = st_data;
    case (st_sz)
      SZ_BYTE: begin
        st_be    = 4'b0001 << st_off;
        st_wdata = {4{st_data[7:0]}};
      end
      SZ_HALF: begin
        st_be    = st_off[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_data[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = st_data;
      end
    endcase
  end

  assign ld_byte = 8'(ld_rdata >> {ld_off, 3'b000});
  assign ld_half = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];

  // Load side: pick the addressed lane(s) and extend to 32 bits.
  always_comb begin
    ld_data = ld_rdata;
    case (ld_sz)
      SZ_BYTE: ld_data = ld_unsigned ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data = ld_unsigned ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/mm_dmem_stage.sv
// MIPS memory stage: consumes the EX/MM register, runs loads/stores over a
// req/ack data-memory bus and registers results into MM/WB.
// Optional macro DM_TIMEOUT_EN: abort a request after TIMEOUT_CYC cycles
// without dm_ack and pulse dm_err; without it REQ waits indefinitely.
module mm_dmem_stage
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_out_alu_ex_mm,
  input  logic [31:0] rd1_data_ex_mm,
  input  logic [1:0]  dm_access_sz_ex_mm,
  input  logic        dm_rw_ex_mm,
  input  logic [31:0] pc_ex_mm,
  input  logic        wr_en_reg_ex_mm,
  input  logic [4:0]  wr_num_ex_mm,
  input  logic [5:0]  opcode_ex_mm,
  output logic        stall_mm,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic [31:0] data_mm_wb,
  output logic        wr_en_reg_mm_wb,
  output logic [4:0]  wr_num_mm_wb,
  output logic [31:0] pc_mm_wb,
  output logic        mis_align_mm_wb,
  output logic        dm_err
);

  mm_state_e   state;
  access_sz_e  ex_sz;
  logic        ex_load;
  logic        ex_mem;
  logic        ex_mis;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_wdata;
  logic [31:0] fmt_ld_data;
  logic        tmo_hit;

  // Context of the outstanding access, captured on REQ entry.
  access_sz_e  req_sz;
  logic [1:0]  req_off;
  logic        req_unsigned;
  logic        req_is_load;
  logic        req_wr_en;
  logic [4:0]  req_wr_num;
  logic [31:0] req_pc;

  assign ex_sz   = access_sz_e'(dm_access_sz_ex_mm);
  assign ex_load = is_load_op(opcode_ex_mm);
  assign ex_mem  = ex_load || is_store_op(opcode_ex_mm);
  assign ex_mis  = ex_mem && is_misaligned(ex_sz, data_out_alu_ex_mm[1:0]);

  dm_lane_fmt u_lane_fmt (
    .st_sz       (ex_sz),
    .st_off      (data_out_alu_ex_mm[1:0]),
    .st_data     (rd1_data_ex_mm),
    .st_be       (fmt_be),
    .st_wdata    (fmt_wdata),
    .ld_sz       (req_sz),
    .ld_off      (req_off),
    .ld_unsigned (req_unsigned),
    .ld_rdata    (dm_rdata),
    .ld_data     (fmt_ld_data)
  );

`ifdef DM_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  assign tmo_hit = (state == REQ) && !dm_ack && (tmo_cnt == 16'(TIMEOUT_CYC - 1));

  // Timeout counter: zero outside REQ, counts REQ cycles without ack; flags the abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      dm_err  <= 1'b0;
    end else begin
      dm_err <= tmo_hit;
      if (state != REQ) begin
        tmo_cnt <= '0;
      end else if (!dm_ack) begin
        tmo_cnt <= tmo_cnt + 16'd1;
      end
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign dm_err  = 1'b0;
`endif

  // Stall: a new aligned access in IDLE, or an access still waiting in REQ.
  always_comb begin
    stall_mm = 1'b0;
    // NOTE: gated by rst_n so the pipeline is never frozen while in reset.
    if (rst_n) begin
      case (state)
        IDLE:    stall_mm = ex_mem && !ex_mis;
        REQ:     stall_mm = !dm_ack && !tmo_hit;
        default: stall_mm = 1'b0;
      endcase
    end
  end

  // Stage FSM, bus request registers and MM/WB pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      dm_req          <= 1'b0;
      dm_we           <= 1'b0;
      dm_addr         <= '0;
      dm_be           <= '0;
      dm_wdata        <= '0;
      data_mm_wb      <= '0;
      wr_en_reg_mm_wb <= 1'b0;
      wr_num_mm_wb    <= '0;
      pc_mm_wb        <= '0;
      mis_align_mm_wb <= 1'b0;
      req_sz          <= SZ_BYTE;
      req_off         <= '0;
      req_unsigned    <= 1'b0;
      req_is_load     <= 1'b0;
      req_wr_en       <= 1'b0;
      req_wr_num      <= '0;
      req_pc          <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      mis_align_mm_wb <= 1'b0;
      case (state)
        IDLE: begin
          if (!ex_mem) begin
            data_mm_wb      <= data_out_alu_ex_mm;
            wr_en_reg_mm_wb <= wr_en_reg_ex_mm;
            wr_num_mm_wb    <= wr_num_ex_mm;
            pc_mm_wb        <= pc_ex_mm;
          end else if (ex_mis) begin
            mis_align_mm_wb <= 1'b1;
            wr_en_reg_mm_wb <= 1'b0;
            wr_num_mm_wb    <= wr_num_ex_mm;
            pc_mm_wb        <= pc_ex_mm;
          end else begin
            state           <= REQ;
            dm_req          <= 1'b1;
            dm_we           <= dm_rw_ex_mm;
            dm_addr         <= {data_out_alu_ex_mm[31:2], 2'b00};
            dm_be           <= fmt_be;
            dm_wdata        <= fmt_wdata;
            req_sz          <= ex_sz;
            req_off         <= data_out_alu_ex_mm[1:0];
            req_unsigned    <= is_unsigned_load(opcode_ex_mm);
            req_is_load     <= ex_load;
            req_wr_en       <= wr_en_reg_ex_mm;
            req_wr_num      <= wr_num_ex_mm;
            req_pc          <= pc_ex_mm;
            wr_en_reg_mm_wb <= 1'b0;
          end
        end
        REQ: begin
          if (dm_ack) begin
            state        <= IDLE;
            dm_req       <= 1'b0;
            wr_num_mm_wb <= req_wr_num;
            pc_mm_wb     <= req_pc;
            if (req_is_load) begin
              data_mm_wb      <= fmt_ld_data;
              wr_en_reg_mm_wb <= req_wr_en;
            end else begin
              wr_en_reg_mm_wb <= 1'b0;
            end
          end else if (tmo_hit) begin
            state           <= IDLE;
            dm_req          <= 1'b0;
            wr_en_reg_mm_wb <= 1'b0;
            pc_mm_wb        <= req_pc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_dmem_stage.sv
// Self-checking bench for mm_dmem_stage: directed cases from the test plan
// plus randomized loads/stores/ALU ops checked against a behavioural model.
module tb_mm_dmem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data_out_alu_ex_mm;
  logic [31:0] rd1_data_ex_mm;
  logic [1:0]  dm_access_sz_ex_mm;
  logic        dm_rw_ex_mm;
  logic [31:0] pc_ex_mm;
  logic        wr_en_reg_ex_mm;
  logic [4:0]  wr_num_ex_mm;
  logic [5:0]  opcode_ex_mm;
  logic        stall_mm;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic [31:0] data_mm_wb;
  logic        wr_en_reg_mm_wb;
  logic [4:0]  wr_num_mm_wb;
  logic [31:0] pc_mm_wb;
  logic        mis_align_mm_wb;
  logic        dm_err;

  int n_checks = 0;
  int n_errors = 0;

  mm_dmem_stage #(.TIMEOUT_CYC(16)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .data_out_alu_ex_mm (data_out_alu_ex_mm),
    .rd1_data_ex_mm     (rd1_data_ex_mm),
    .dm_access_sz_ex_mm (dm_access_sz_ex_mm),
    .dm_rw_ex_mm        (dm_rw_ex_mm),
    .pc_ex_mm           (pc_ex_mm),
    .wr_en_reg_ex_mm    (wr_en_reg_ex_mm),
    .wr_num_ex_mm       (wr_num_ex_mm),
    .opcode_ex_mm       (opcode_ex_mm),
    .stall_mm           (stall_mm),
    .dm_req             (dm_req),
    .dm_we              (dm_we),
    .dm_addr            (dm_addr),
    .dm_be              (dm_be),
    .dm_wdata           (dm_wdata),
    .dm_ack             (dm_ack),
    .dm_rdata           (dm_rdata),
    .data_mm_wb         (data_mm_wb),
    .wr_en_reg_mm_wb    (wr_en_reg_mm_wb),
    .wr_num_mm_wb       (wr_num_mm_wb),
    .pc_mm_wb           (pc_mm_wb),
    .mis_align_mm_wb    (mis_align_mm_wb),
    .dm_err             (dm_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  function automatic bit m_is_load(input logic [5:0] op);
    return op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
  endfunction

  function automatic bit m_is_store(input logic [5:0] op);
    return op inside {6'h28, 6'h29, 6'h2B};
  endfunction

  // Access width in bytes implied by the opcode.
  function automatic int m_width(input logic [5:0] op);
    if (op inside {6'h20, 6'h24, 6'h28}) return 1;
    if (op inside {6'h21, 6'h25, 6'h29}) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] m_be(input int width, input int off);
    int mask;
    mask = (1 << width) - 1;
    return 4'(mask << off);
  endfunction

  function automatic logic [31:0] m_wdata(input int width, input logic [31:0] d);
    if (width == 1) return {24'h0, d[7:0]} * 32'h0101_0101;
    if (width == 2) return {16'h0, d[15:0]} * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [5:0] op, input int off, input logic [31:0] r);
    logic [31:0] v;
    v = r >> (8 * off);
    case (op)
      6'h20:   return (v & 32'h80) != 0 ? (v & 32'hFF) | 32'hFFFF_FF00 : v & 32'hFF;
      6'h24:   return v & 32'hFF;
      6'h21:   return (v & 32'h8000) != 0 ? (v & 32'hFFFF) | 32'hFFFF_0000 : v & 32'hFFFF;
      6'h25:   return v & 32'hFFFF;
      default: return r;
    endcase
  endfunction

  task automatic drive_nop();
    opcode_ex_mm       = 6'h00;
    wr_en_reg_ex_mm    = 1'b0;
    wr_num_ex_mm       = 5'd0;
    data_out_alu_ex_mm = 32'h0;
    rd1_data_ex_mm     = 32'h0;
    dm_access_sz_ex_mm = 2'b00;
    dm_rw_ex_mm        = 1'b0;
    pc_ex_mm           = 32'h0;
  endtask

  // Present one EX/MM op (called at posedge+1), service it, check results.
  task automatic run_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rd1,
                        input logic wen, input logic [4:0] wn, input int delay,
                        input logic [31:0] rdata);
    int          width;
    int          off;
    int          stalls;
    bit          mem;
    bit          mis;
    logic [31:0] pc;
    width = m_width(op);
    off   = int'(addr[1:0]);
    mem   = m_is_load(op) || m_is_store(op);
    mis   = mem && (off % width) != 0;
    pc    = $urandom & 32'hFFFF_FFFC;
    opcode_ex_mm       = op;
    data_out_alu_ex_mm = addr;
    rd1_data_ex_mm     = rd1;
    wr_en_reg_ex_mm    = wen;
    wr_num_ex_mm       = wn;
    pc_ex_mm           = pc;
    dm_rw_ex_mm        = m_is_store(op);
    dm_access_sz_ex_mm = (width == 1) ? 2'b00 : (width == 2) ? 2'b01 : 2'b10;
    #1;
    if (!mem) begin
      check("alu_stall", stall_mm, 0);
      @(posedge clk); #1;
      check("alu_data", data_mm_wb, addr);
      check("alu_wr_en", wr_en_reg_mm_wb, wen);
      check("alu_wr_num", wr_num_mm_wb, wn);
      check("alu_pc", pc_mm_wb, pc);
      check("alu_req", dm_req, 0);
    end else if (mis) begin
      check("mis_stall", stall_mm, 0);
      @(posedge clk); #1;
      check("mis_flag", mis_align_mm_wb, 1);
      check("mis_wr_en", wr_en_reg_mm_wb, 0);
      check("mis_pc", pc_mm_wb, pc);
      check("mis_req", dm_req, 0);
      drive_nop();
      @(posedge clk); #1;
      check("mis_clear", mis_align_mm_wb, 0);
    end else begin
      check("idle_stall", stall_mm, 1);
      stalls = 1;
      @(posedge clk); #1;
      check("req_wr_en_bubble", wr_en_reg_mm_wb, 0);
      for (int k = 0; k <= delay; k++) begin
        check("bus_req", dm_req, 1);
        check("bus_we", dm_we, m_is_store(op));
        check("bus_addr", dm_addr, addr & 32'hFFFF_FFFC);
        check("bus_be", dm_be, m_be(width, off));
        if (m_is_store(op)) check("bus_wdata", dm_wdata, m_wdata(width, rd1));
        if (k == delay) begin
          dm_ack   = 1'b1;
          dm_rdata = rdata;
        end
        #1;
        if (stall_mm) stalls++;
        @(posedge clk); #1;
        dm_ack   = 1'b0;
        dm_rdata = $urandom;
      end
      check("stall_cycles", stalls, delay + 1);
      check("done_req", dm_req, 0);
      check("done_pc", pc_mm_wb, pc);
      if (m_is_load(op)) begin
        check("load_data", data_mm_wb, m_load(op, off, rdata));
        check("load_wr_en", wr_en_reg_mm_wb, wen);
        check("load_wr_num", wr_num_mm_wb, wn);
      end else begin
        check("store_wr_en", wr_en_reg_mm_wb, 0);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"}, stall_mm, 0);
    check({tag, "_req"}, dm_req, 0);
    check({tag, "_we"}, dm_we, 0);
    check({tag, "_addr"}, dm_addr, 0);
    check({tag, "_be"}, dm_be, 0);
    check({tag, "_wdata"}, dm_wdata, 0);
    check({tag, "_data"}, data_mm_wb, 0);
    check({tag, "_wr_en"}, wr_en_reg_mm_wb, 0);
    check({tag, "_wr_num"}, wr_num_mm_wb, 0);
    check({tag, "_pc"}, pc_mm_wb, 0);
    check({tag, "_mis"}, mis_align_mm_wb, 0);
    check({tag, "_err"}, dm_err, 0);
  endtask

  logic [5:0] op_tab [10] = '{6'h00, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h0F};

  initial begin
    dm_ack   = 1'b0;
    dm_rdata = 32'h0;
    drive_nop();
    // Hold a memory op on the inputs during reset: stall must still be 0.
    opcode_ex_mm = 6'h23;
    rst_n = 1'b0;
    #12;
    check_all_zero("reset");
    drive_nop();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases.
    run_op(6'h00, 32'h0000_1234, 32'h0, 1'b1, 5'd5, 0, 32'h0);
    run_op(6'h20, 32'h0000_0103, 32'h0, 1'b1, 5'd7, 3, 32'h80FF_FF00);
    run_op(6'h24, 32'h0000_0103, 32'h0, 1'b1, 5'd7, 3, 32'h80FF_FF00);
    run_op(6'h29, 32'h0000_0202, 32'hAAAA_BEEF, 1'b0, 5'd0, 0, 32'h0);
    run_op(6'h23, 32'h0000_0101, 32'h0, 1'b1, 5'd3, 0, 32'h0);

    // Ack while idle is ignored.
    drive_nop();
    data_out_alu_ex_mm = 32'h0000_0055;
    dm_ack = 1'b1;
    #1;
    check("idle_ack_stall", stall_mm, 0);
    @(posedge clk); #1;
    dm_ack = 1'b0;
    check("idle_ack_req", dm_req, 0);
    check("idle_ack_data", data_mm_wb, 32'h55);

    // Reset in the middle of a request.
    opcode_ex_mm       = 6'h23;
    data_out_alu_ex_mm = 32'h0000_0400;
    dm_access_sz_ex_mm = 2'b10;
    wr_en_reg_ex_mm    = 1'b1;
    wr_num_ex_mm       = 5'd9;
    pc_ex_mm           = 32'h0000_0040;
    @(posedge clk); #1;
    check("pre_reset_req", dm_req, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_req_reset");
    drive_nop();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(6'h23, 32'h0000_0100, 32'h0, 1'b1, 5'd4, 1, 32'hDEAD_BEEF);

`ifdef DM_TIMEOUT_EN
    // No ack: abort after 16 REQ cycles with a single dm_err pulse.
    opcode_ex_mm       = 6'h23;
    data_out_alu_ex_mm = 32'h0000_0300;
    dm_access_sz_ex_mm = 2'b10;
    wr_en_reg_ex_mm    = 1'b1;
    wr_num_ex_mm       = 5'd2;
    pc_ex_mm           = 32'h0000_0080;
    @(posedge clk); #1;
    for (int k = 0; k < 16; k++) begin
      check("tmo_req", dm_req, 1);
      check("tmo_err_low", dm_err, 0);
      if (k == 15) drive_nop();
      @(posedge clk); #1;
    end
    check("tmo_req_drop", dm_req, 0);
    check("tmo_err_pulse", dm_err, 1);
    check("tmo_wr_en", wr_en_reg_mm_wb, 0);
    @(posedge clk); #1;
    check("tmo_err_clear", dm_err, 0);
    // Ack on the 16th REQ cycle wins over the timeout.
    run_op(6'h23, 32'h0000_0300, 32'h0, 1'b1, 5'd2, 15, 32'h1357_9BDF);
    check("tmo_ack_err", dm_err, 0);
`endif

    // Randomized mix of ALU ops, loads and stores.
    for (int i = 0; i < 60; i++) begin
      run_op(op_tab[$urandom_range(0, 9)], $urandom, $urandom, 1'($urandom),
             5'($urandom), $urandom_range(0, 4), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mm_dmem_stage.md
Name: mm_dmem_stage

Overview:
- Memory-stage consumer of the EX/MM pipeline register.
- Decodes the load/store opcode and checks alignment.
- Drives a request/acknowledge data-memory bus with byte enables, and formats load data (byte/half extraction, sign or zero extension).
- Registers results into the MM/WB stage. Raises stall_mm to freeze upstream stages while a memory access is outstanding.

Parameters:
- TIMEOUT_CYC, 16, cycles in REQ without dm_ack before abort (used only with DM_TIMEOUT_EN).

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- data_out_alu_ex_mm  in  32  ALU result; byte address for loads/stores
- rd1_data_ex_mm  in  32  store data
- dm_access_sz_ex_mm  in  2  00 byte, 01 half, 10 word, 11 treated as word
- dm_rw_ex_mm  in  1  1 write, 0 read
- pc_ex_mm  in  32  instruction PC
- wr_en_reg_ex_mm  in  1  register write enable
- wr_num_ex_mm  in  5  destination register
- opcode_ex_mm  in  6  MIPS opcode
- stall_mm  out  1  high: EX/MM and earlier stages hold
- dm_req  out  1  bus request
- dm_we  out  1  bus write
- dm_addr  out  32  word address {addr[31:2],2'b00}
- dm_be  out  4  byte enables; lane 0 = bits 7:0 (little-endian)
- dm_wdata  out  32  store data, lane-replicated
- dm_ack  in  1  access complete; dm_rdata valid this cycle
- dm_rdata  in  32  read data
- data_mm_wb  out  32  load result or ALU pass-through
- wr_en_reg_mm_wb  out  1
- wr_num_mm_wb  out  5
- pc_mm_wb  out  32
- mis_align_mm_wb  out  1  one-cycle misalignment flag
- dm_err  out  1  one-cycle timeout flag

Behaviour:
- Memory ops are decoded from opcode only:
  - loads: lb 0x20, lh 0x21, lw 0x23, lbu 0x24, lhu 0x25
  - stores: sb 0x28, sh 0x29, sw 0x2B
  - all other opcodes are non-memory.
- Misaligned access: half with addr[0]=1, or word with addr[1:0]≠0.
- FSM has two states, IDLE and REQ.
- IDLE:
  - Non-memory op: at the next edge, data_mm_wb <= data_out_alu_ex_mm and wr_en/wr_num/pc are copied. Latency is 1 and stall_mm=0.
  - Aligned memory op: stall_mm=1 combinationally. At the edge, bus fields are registered and the FSM goes to REQ. MM/WB gets a bubble (wr_en_reg_mm_wb=0).
  - Misaligned memory op: no request and no stall. At the edge, mis_align_mm_wb=1, wr_en_reg_mm_wb=0, pc_mm_wb=pc_ex_mm.
- REQ:
  - dm_req=1; dm_we/addr/be/wdata are held stable until ack.
  - stall_mm = !dm_ack.
  - On dm_ack: the next edge loads MM/WB with formatted data (loads) or wr_en=0 (stores), and the FSM returns to IDLE.
  - Minimum op-to-MM/WB latency is 2 edges (ack in first REQ cycle).
- dm_ack seen in IDLE is ignored.
- Byte enables:
  - byte: 0001<<addr[1:0]
  - half: 0011 (addr[1]=0) or 1100 (addr[1]=1)
  - word: 1111
- Store data replication:
  - byte: {4{rd1[7:0]}}
  - half: {2{rd1[15:0]}}
  - word: rd1
- Load data: select lane(s) by addr[1:0]; lb/lh sign-extend, lbu/lhu zero-extend, lw passes all 32 bits.
- mis_align_mm_wb and dm_err are cleared the edge after being set.
- Reset (asynchronous):
  - FSM → IDLE.
  - Every output register → 0: dm_req, dm_we, dm_addr, dm_be, dm_wdata, data_mm_wb, wr_en_reg_mm_wb, wr_num_mm_wb, pc_mm_wb, mis_align_mm_wb, dm_err.
  - stall_mm is 0 while in reset.
  - Reset mid-REQ drops dm_req immediately; memory must abandon the access.

Optional Feature:
- Macro: DM_TIMEOUT_EN.
- Defined:
  - A cycle counter is cleared on REQ entry and increments each REQ cycle without ack.
  - At count == TIMEOUT_CYC-1 without ack: dm_req drops, FSM → IDLE, dm_err pulses 1 cycle, and MM/WB gets wr_en_reg_mm_wb=0.
  - An ack in the same cycle as the timeout wins.
- Undefined: REQ waits indefinitely; dm_err is tied 0 and the port remains.

Decomposition:
- Package mips_pkg:
  - opcode constants (OP_LB…OP_SW)
  - access-size enum
  - FSM state enum {IDLE, REQ}
- Sub-module dm_lane_fmt (purely combinational):
  - store side: byte-enable generation and store replication
  - load side: lane extraction and sign/zero extension
- FSM, stall and MM/WB registers stay in mm_dmem_stage.

Test Plan:
- addu result 0x1234 (opcode 0x00, wr_en=1, wr_num=5) → next edge data_mm_wb=0x1234, wr_en=1, wr_num=5, stall_mm=0.
- lb addr 0x103, ack after 3 REQ cycles with rdata 0x80FF_FF00 → dm_be=1000, stall_mm high 4 cycles, data_mm_wb=0xFFFFFF80; repeat as lbu → 0x00000080.
- sh addr 0x202, rd1=0xAAAA_BEEF, immediate ack → dm_we=1, dm_be=1100, dm_wdata=0xBEEFBEEF, wr_en_reg_mm_wb=0.
- lw addr 0x101 → no dm_req, mis_align_mm_wb=1 for one cycle, wr_en_reg_mm_wb=0, stall_mm=0.
- rst_n low during REQ → dm_req=0 immediately, all outputs 0; after release a lw to 0x100 completes normally.
- With DM_TIMEOUT_EN, TIMEOUT_CYC=16, no ack → dm_req drops after 16 REQ cycles, dm_err pulses once; an ack on cycle 16 instead completes the load.
